rotation_mode: RTL and testbench

- Rotation-mode CORDIC engine. It is the consumer of the 8-bit direction vector sign_d produced by the vectoring-mode block.
- Replays the recorded micro-rotation directions onto another 13-bit signed (X,Y) pair, i.e. applies the same Givens rotation to the remaining matrix columns in the QR array.
- Two micro-rotations per cycle, 8 iterations total. The result is gain-compensated by K before output.

---
 rtl/rotation_mode_if.sv | 23 ++
 rtl/rotation_mode.sv | 155 +++++++++++++++
 tb/tb_rotation_mode.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rotation_mode_if.sv
// Operand/result bundle for the rotation-mode CORDIC engine.
// The master drives operands and start. The slave (the engine) returns
// the rotated pair together with busy/done status.
interface rotation_mode_if;
  logic signed [12:0] ori_X;
  logic signed [12:0] ori_Y;
  logic        [7:0]  sign_d;
  logic               start;
  logic signed [12:0] rot_X;
  logic signed [12:0] rot_Y;
  logic               busy;
  logic               done;

  modport master (
    output ori_X, ori_Y, sign_d, start,
    input  rot_X, rot_Y, busy, done
  );

  modport slave (
    input  ori_X, ori_Y, sign_d, start,
    output rot_X, rot_Y, busy, done
  );
endinterface

// File: rtl/rotation_mode.sv
// Rotation-mode CORDIC engine.
// It replays the 8 recorded micro-rotation directions (sign_d) onto a new
// 13-bit (X,Y) pair. Each EXE cycle performs two micro-rotations, so one
// operation is IDLE -> 4x EXE -> DONE. The result is scaled by the CORDIC
// gain compensation K while in DONE.
module rotation_mode #(
  parameter logic [9:0] K = 10'b1001101110
) (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active-low
  rotation_mode_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXE  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Working (X,Y) pair at the 13-bit datapath width.
  typedef struct packed {
    logic signed [12:0] x;
    logic signed [12:0] y;
  } vec_t;

  // Raw 14-bit sums of one micro-rotation, before truncation back to 13 bits.
  typedef struct packed {
    logic signed [13:0] x;
    logic signed [13:0] y;
  } wide_t;

  // One micro-rotation: j is the shift amount, d is the recorded direction.
  function automatic wide_t micro_rot(input vec_t v, input logic [2:0] j, input logic d);
    logic signed [12:0] x;
    logic signed [12:0] y;
    logic signed [12:0] xs;
    logic signed [12:0] ys;
    wide_t              r;
    x  = v.x;
    y  = v.y;
    xs = x >>> j;
    ys = y >>> j;
    if (d) begin
      r.x = {x[12], x} - {ys[12], ys};
      r.y = {y[12], y} + {xs[12], xs};
    end else begin
      r.x = {x[12], x} + {ys[12], ys};
      r.y = {y[12], y} - {xs[12], xs};
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  vec_t        work_q,  work_d;
  logic [7:0]  dir_q,   dir_d;

  wide_t       w0, w1;
  vec_t        v0, v1;
  logic [2:0]  j_odd;

  logic signed [24:0] k_ext;
  logic signed [24:0] x_ext;
  logic signed [24:0] y_ext;
  logic signed [24:0] px;
  logic signed [24:0] py;

  // Two chained micro-rotations: iteration cnt_q, then cnt_q+1.
  // The 14-bit sum is reduced to 13 bits by dropping bit 12 and keeping the
  // sign bit. This matches the vectoring block bit-for-bit, with no saturation.
  always_comb begin
    j_odd = cnt_q | 3'd1;
    w0    = micro_rot(work_q, cnt_q, dir_q[cnt_q]);
    v0.x  = {w0.x[13], w0.x[11:0]};
    v0.y  = {w0.y[13], w0.y[11:0]};
    w1    = micro_rot(v0, j_odd, dir_q[j_odd]);
    v1.x  = {w1.x[13], w1.x[11:0]};
    v1.y  = {w1.y[13], w1.y[11:0]};
  end

  // Next-state, counter and capture logic.
  always_comb begin
    // NOTE: every signal gets a default first, so that no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = 3'd0;
    work_d  = work_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = EXE;
          work_d.x = bus.ori_X;
          work_d.y = bus.ori_Y;
          dir_d    = bus.sign_d;
        end
      end
      EXE: begin
        work_d = v1;
        if (cnt_q == 3'd6) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd2;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, working pair and captured directions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      work_q  <= '0;
      dir_q   <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment, so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
    end
  end

  // Gain compensation: 13-bit signed times unsigned K, formed at 25 bits.
  assign k_ext = $signed({15'd0, K});
  assign x_ext = {{12{work_q.x[12]}}, work_q.x};
  assign y_ext = {{12{work_q.y[12]}}, work_q.y};
  assign px    = x_ext * k_ext;
  assign py    = y_ext * k_ext;

  // Outputs: status comes from the state, and the result is visible only in DONE.
  always_comb begin
    bus.rot_X = '0;
    bus.rot_Y = '0;
    bus.busy  = (state_q == EXE) || (state_q == DONE);
    bus.done  = (state_q == DONE);
    if (state_q == DONE) begin
      bus.rot_X = {px[24], px[21:10]};
      bus.rot_Y = {py[24], py[21:10]};
    end
  end

  // These bits are dropped on purpose by the truncation rules above.
  logic unused_bits;
  assign unused_bits = ^{w0.x[12], w0.y[12], w1.x[12], w1.y[12],
                         px[23:22], px[9:0], py[23:22], py[9:0]};

endmodule

// File: tb/tb_rotation_mode.sv
// Scoreboard bench for rotation_mode. Stimulus pushes expected results.
// A negedge monitor pops and compares them whenever done is high.
module tb_rotation_mode;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rotation_mode_if bus();

  rotation_mode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keep bits [11:0] of a value in the 14-bit range, and take bit 13 as the sign.
  function automatic int red13(input int s);
    return (s < 0 ? -4096 : 0) + (s & 'hFFF);
  endfunction

  function automatic exp_t model(input int x0, input int y0, input logic [7:0] s);
    int   x, y, nx, ny, p;
    exp_t e;
    x = x0;
    y = y0;
    for (int j = 0; j < 8; j++) begin
      if (s[j]) begin
        nx = x - (y >>> j);
        ny = y + (x >>> j);
      end else begin
        nx = x + (y >>> j);
        ny = y - (x >>> j);
      end
      x = red13(nx);
      y = red13(ny);
    end
    p   = x * 622;
    e.x = (p < 0 ? -4096 : 0) + ((p >>> 10) & 'hFFF);
    p   = y * 622;
    e.y = (p < 0 ? -4096 : 0) + ((p >>> 10) & 'hFFF);
    return e;
  endfunction

  // Monitor: compare on done, otherwise require zero outputs.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rot_X", int'($signed(bus.rot_X)), e.x);
        check("rot_Y", int'($signed(bus.rot_Y)), e.y);
      end
    end else begin
      check("rot_X_zero_when_idle", int'($signed(bus.rot_X)), 0);
      check("rot_Y_zero_when_idle", int'($signed(bus.rot_Y)), 0);
    end
  end

  task automatic push(input int ex, input int ey);
    exp_t e;
    e.x = ex;
    e.y = ey;
    sb.push_back(e);
  endtask

  // Entered at posedge+1 of an IDLE cycle, and returns at posedge+1 of the next IDLE cycle.
  task automatic run_op(input int x, input int y, input logic [7:0] s, input int ex, input int ey);
    bus.ori_X  = 13'(x);
    bus.ori_Y  = 13'(y);
    bus.sign_d = s;
    bus.start  = 1'b1;
    push(ex, ey);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
  endtask

  // Same as run_op, but also checks busy/done cycle by cycle.
  task automatic latency_op(input int x, input int y, input logic [7:0] s, input int ex, input int ey);
    bus.ori_X  = 13'(x);
    bus.ori_Y  = 13'(y);
    bus.sign_d = s;
    bus.start  = 1'b1;
    push(ex, ey);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("busy_n+%0d", k), int'(bus.busy), 1);
      check($sformatf("done_n+%0d", k), int'(bus.done), (k == 5) ? 1 : 0);
      @(posedge clk); #1;
    end
    check("busy_n+6", int'(bus.busy), 0);
    check("done_n+6", int'(bus.done), 0);
  endtask

  initial begin
    exp_t e;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.ori_X  = '0;
    bus.ori_Y  = '0;
    bus.sign_d = '0;
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_rot_X", int'($signed(bus.rot_X)), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Latency and handshake timing: 1000, -300 with directions 3C.
    e = model(1000, -300, 8'h3C);
    latency_op(1000, -300, 8'h3C, e.x, e.y);

    // Inverse pairing with the vectoring result for (1000,1000): directions 7C.
    run_op(1000, 1000, 8'h7C, 1415, 9);

    // Negative/shift corner, hand-computed for FF; model used for 00.
    run_op(-1, -4096, 8'hFF, -603, 1143);
    e = model(-1, -4096, 8'h00);
    run_op(-1, -4096, 8'h00, e.x, e.y);

    // Reset in the middle of EXE: abort, with no done pulse.
    bus.ori_X  = 13'sd1000;
    bus.ori_Y  = -13'sd300;
    bus.sign_d = 8'h3C;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_rot_X", int'($signed(bus.rot_X)), 0);
    check("abort_rot_Y", int'($signed(bus.rot_Y)), 0);
    repeat (4) begin
      @(negedge clk);
      check("abort_hold_busy", int'(bus.busy), 0);
      check("abort_hold_done", int'(bus.done), 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    latency_op(0, 0, 8'h5A, 0, 0);

    // Start held high for 20 cycles with operands changing every cycle.
    bus.start = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k < 20) begin
        bus.ori_X  = 13'(k * 151 - 1500);
        bus.ori_Y  = 13'(900 - k * 97);
        bus.sign_d = 8'(k * 29 + 3);
        if (k % 6 == 0) begin
          e = model(k * 151 - 1500, 900 - k * 97, 8'(k * 29 + 3));
          sb.push_back(e);
        end
      end else begin
        bus.start = 1'b0;
      end
      check($sformatf("b2b_done_k%0d", k), int'(bus.done), ((k % 6 == 5) && (k <= 23)) ? 1 : 0);
      @(posedge clk); #1;
    end

    // Random regression against the model.
    for (int n = 0; n < 10000; n++) begin
      int         rx, ry;
      logic [7:0] rs;
      rx = int'($urandom_range(8191, 0)) - 4096;
      ry = int'($urandom_range(8191, 0)) - 4096;
      rs = 8'($urandom);
      e  = model(rx, ry, rs);
      run_op(rx, ry, rs, e.x, e.y);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
